// File: rtl/fdc_pkg.sv
// Shared definitions for the FDC host link: opcodes, framing bytes,
// request/completion bit positions and the bridge state encoding.
package fdc_pkg;

    localparam logic [7:0] OP_STAT   = 8'h01;
    localparam logic [7:0] OP_CTRL   = 8'h02;
    localparam logic [7:0] OP_RDAT   = 8'h03;
    localparam logic [7:0] OP_WDAT   = 8'h04;

    localparam logic [7:0] SYNC_BYTE = 8'h5A;
    localparam logic [7:0] PAD_BYTE  = 8'hFF;

    localparam int ACK_BIT   = 16;
    localparam int DONE_BIT  = 4;
    localparam int ERR_BIT   = 3;
    localparam int SEEK0_BIT = 7;
    localparam int SEEK1_BIT = 8;

    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_STAT,
        ST_CTRL,
        ST_RDAT,
        ST_WDAT,
        ST_SINK
    } fdc_state_e;

    // Completion bits the FDC acknowledges by raising its ACK request bit.
    function automatic logic [31:0] ack_clear_mask();
        logic [31:0] m;
        m            = '0;
        m[DONE_BIT]  = 1'b1;
        m[ERR_BIT]   = 1'b1;
        m[SEEK0_BIT] = 1'b1;
        m[SEEK1_BIT] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI slave byte engine: synchronises the pins, detects sck edges and
// shifts whole bytes in on sck rise and out on sck fall.
module spi_slave_byte
    import fdc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       ss_active
);

    logic       sck_meta, sck_sync, sck_prev;
    logic       ss_meta, ss_sync, ss_prev;
    logic       mosi_meta, mosi_sync;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;

    logic sck_rise, sck_fall, ss_fall;

    assign sck_rise  = sck_sync & ~sck_prev;
    assign sck_fall  = ~sck_sync & sck_prev;
    assign ss_fall   = ~ss_sync & ss_prev;
    assign ss_active = ~ss_sync;
    assign spi_miso  = tx_sr[7];

    // Select syncs reset to "asserted" so a select held low across reset
    // produces no falling edge: the MCU has to deselect before retrying.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            ss_meta   <= 1'b0;
            ss_sync   <= 1'b0;
            ss_prev   <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
        end else begin
            sck_meta  <= spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ss_meta   <= spi_ss_n;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;

            if (ss_fall) begin
                bit_cnt <= '0;
                tx_sr   <= SYNC_BYTE;
            end else if (ss_active) begin
                if (sck_rise) begin
                    rx_sr   <= {rx_sr[5:0], mosi_sync};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte  <= {rx_sr, mosi_sync};
                        rx_valid <= 1'b1;
                    end
                end
                // The fall after the 8th rise opens the next byte: take its MSB now.
                if (sck_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_sr   <= tx_byte;
                        tx_load <= 1'b1;
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fdc_spi_bridge.sv
// Host-side SPI link for the floppy controller: the MCU reads the request
// word, writes the completion word and streams sector bytes to/from the FDC FIFOs.
module fdc_spi_bridge
    import fdc_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter bit AUTO_ACK     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [31:0] fdc_sr,
    output logic [31:0] fdc_cr,
    output logic [7:0]  fdc_wdata,
    output logic        fdc_wstb,
    input  logic [7:0]  fdc_rdata,
    output logic        fdc_rstb,
    output fdc_state_e  dbg_state
);

    localparam logic [CNT_W-1:0] SECTOR_MAX = CNT_W'(SECTOR_BYTES);

    fdc_state_e       state_q, state_d;
    logic [7:0]       rx_byte, tx_byte;
    logic             rx_valid, tx_load, ss_active, ss_act_q;
    logic             ss_fall, ss_rise, live;
    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      sr_snap;
    logic [23:0]      shadow;
    logic [7:0]       rd_buf;
    logic             wstb_pend, sr_ack_q, ack_rise, ctrl_commit;

    spi_slave_byte u_spi (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (spi_sck),
        .spi_ss_n  (spi_ss_n),
        .spi_mosi  (spi_mosi),
        .tx_byte   (tx_byte),
        .spi_miso  (spi_miso),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_load   (tx_load),
        .ss_active (ss_active)
    );

    assign ss_fall     = ss_active & ~ss_act_q;
    assign ss_rise     = ~ss_active & ss_act_q;
    assign live        = ~ss_fall & ~ss_rise;
    assign ack_rise    = fdc_sr[ACK_BIT] & ~sr_ack_q;
    assign ctrl_commit = live && (state_q == ST_CTRL) && rx_valid && (byte_cnt == CNT_W'(3));
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ss_act_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ss_act_q <= ss_active;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ss_rise) begin
            state_d = ST_IDLE;
        end else if (ss_fall) begin
            state_d = ST_CMD;
        end else if (state_q == ST_CMD && rx_valid) begin
            case (rx_byte)
                OP_STAT: state_d = ST_STAT;
                OP_CTRL: state_d = ST_CTRL;
                OP_RDAT: state_d = ST_RDAT;
                OP_WDAT: state_d = ST_WDAT;
                default: state_d = ST_SINK;
            endcase
        end
    end

    // Byte the slave picks up at the next byte boundary.
    always_comb begin
        tx_byte = PAD_BYTE;
        case (state_q)
            ST_STAT: tx_byte = sr_snap[31:24];
            ST_RDAT: tx_byte = rd_buf;
            default: tx_byte = PAD_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            sr_snap   <= '0;
            shadow    <= '0;
            rd_buf    <= '0;
            wstb_pend <= 1'b0;
            sr_ack_q  <= 1'b0;
            fdc_cr    <= '0;
            fdc_wdata <= '0;
            fdc_wstb  <= 1'b0;
            fdc_rstb  <= 1'b0;
        end else begin
            fdc_rstb  <= 1'b0;
            wstb_pend <= 1'b0;
            fdc_wstb  <= wstb_pend && (state_q == ST_WDAT);
            sr_ack_q  <= fdc_sr[ACK_BIT];

            if (ss_fall) begin
                byte_cnt <= '0;
            end else if (live) begin
                case (state_q)
                    ST_CMD: begin
                        if (rx_valid) begin
                            if (rx_byte == OP_STAT) begin
                                sr_snap <= fdc_sr;
                            end else if (rx_byte == OP_RDAT) begin
                                rd_buf   <= fdc_rdata;
                                fdc_rstb <= 1'b1;
                                byte_cnt <= CNT_W'(1);
                            end
                        end
                    end
                    ST_STAT: begin
                        if (tx_load) begin
                            sr_snap <= {sr_snap[23:0], PAD_BYTE};
                        end
                    end
                    ST_CTRL: begin
                        if (rx_valid && byte_cnt < CNT_W'(4)) begin
                            shadow   <= {shadow[15:0], rx_byte};
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                    ST_RDAT: begin
                        if (tx_load) begin
                            if (byte_cnt < SECTOR_MAX) begin
                                rd_buf   <= fdc_rdata;
                                fdc_rstb <= 1'b1;
                                byte_cnt <= byte_cnt + CNT_W'(1);
                            end else begin
                                rd_buf <= PAD_BYTE;
                            end
                        end
                    end
                    ST_WDAT: begin
                        if (rx_valid && byte_cnt < SECTOR_MAX) begin
                            fdc_wdata <= rx_byte;
                            wstb_pend <= 1'b1;
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end

            // A CTRL commit outranks an acknowledge landing on the same clock.
            if (ctrl_commit) begin
                fdc_cr <= {shadow, rx_byte};
            end else if (AUTO_ACK && ack_rise) begin
                fdc_cr <= fdc_cr & ~ack_clear_mask();
            end
        end
    end

endmodule
